// File: rtl/taxi_fare_collector.sv
// taxi_fare_collector
//
// Payment end of the taxi meter. When a passenger leaves, the fare for that
// seat is snapshotted into fare_due. Coins are then collected until the fare
// is covered, change is returned and the meter is told to clear the seat.
// A cancel or an idle timeout abandons the payment and returns any coins.
// The block also keeps a running collected-cash total and a saturating count
// of unpaid exits.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for exit_req
//   PAY    | accepting coins against fare_due, idle timer running
//   SETTLE | one cycle: emit change, clear seat, book fare into total
//   REFUND | one cycle: return coins (if any), count unpaid exit
//
// Ports:
//   clock, reset_n              clock (rising edge), async active-low reset
//   exit_req, exit_seat         passenger leaving seat 0-3 or 4 (VIP)
//   s0cost..s3cost, vip_cost    live fares from the meter
//   coin_valid, coin_amount     one coin per cycle
//   cancel                      passenger aborts payment
//   busy                        high while a payment is in progress
//   fare_due, paid_sum          latched fare and coins so far
//   seat_clear, seat_clear_idx  pulse telling the meter to zero a seat
//   change_valid/amount         change pulse and amount
//   refund_valid/amount         refund pulse and amount
//   collected_total             sum of all settled fares
//   unpaid_count                aborted / timed-out exits, saturating
//   err_bad_seat                pulse on exit_req with seat 5-7
//
// All outputs are registered. busy is the registered view of "state is not
// IDLE", so it trails the state by one cycle: it rises one cycle after PAY is
// entered and falls one cycle after SETTLE/REFUND return to IDLE.

module taxi_fare_collector #(
  parameter int FARE_W  = 32,
  parameter int COIN_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              exit_req,
  input  logic [2:0]        exit_seat,
  input  logic [FARE_W-1:0] s0cost,
  input  logic [FARE_W-1:0] s1cost,
  input  logic [FARE_W-1:0] s2cost,
  input  logic [FARE_W-1:0] s3cost,
  input  logic [FARE_W-1:0] vip_cost,
  input  logic              coin_valid,
  input  logic [COIN_W-1:0] coin_amount,
  input  logic              cancel,
  output logic              busy,
  output logic [FARE_W-1:0] fare_due,
  output logic [FARE_W-1:0] paid_sum,
  output logic              seat_clear,
  output logic [2:0]        seat_clear_idx,
  output logic              change_valid,
  output logic [FARE_W-1:0] change_amount,
  output logic              refund_valid,
  output logic [FARE_W-1:0] refund_amount,
  output logic [FARE_W-1:0] collected_total,
  output logic [CNT_W-1:0]  unpaid_count,
  output logic              err_bad_seat
);

  // Idle timer is a down-counter: loaded with TIMEOUT-1 on entry to PAY and
  // on every coin, decremented on coin-less cycles; a coin-less cycle seen
  // at zero is the TIMEOUT-th idle cycle and abandons the payment.
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY    = 2'd1,
    SETTLE = 2'd2,
    REFUND = 2'd3
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [2:0]        seat;
  logic [FARE_W-1:0] sel_cost;
  logic [FARE_W-1:0] coin_ext;
  logic [FARE_W-1:0] sum_next;
  logic              seat_legal;

  always_comb begin
    sel_cost = '0;
    case (exit_seat)
      3'd0:    sel_cost = s0cost;
      3'd1:    sel_cost = s1cost;
      3'd2:    sel_cost = s2cost;
      3'd3:    sel_cost = s3cost;
      3'd4:    sel_cost = vip_cost;
      default: sel_cost = '0;
    endcase
  end

  assign seat_legal = (exit_seat <= 3'd4);
  assign coin_ext   = FARE_W'(coin_amount);
  // Wraps modulo 2^FARE_W; a wrapped sum simply fails the coverage compare.
  assign sum_next   = paid_sum + coin_ext;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      timer           <= '0;
      seat            <= '0;
      busy            <= 1'b0;
      fare_due        <= '0;
      paid_sum        <= '0;
      seat_clear      <= 1'b0;
      seat_clear_idx  <= '0;
      change_valid    <= 1'b0;
      change_amount   <= '0;
      refund_valid    <= 1'b0;
      refund_amount   <= '0;
      collected_total <= '0;
      unpaid_count    <= '0;
      err_bad_seat    <= 1'b0;
    end else begin
      seat_clear   <= 1'b0;
      change_valid <= 1'b0;
      refund_valid <= 1'b0;
      err_bad_seat <= 1'b0;
      busy         <= (state != IDLE);

      case (state)
        IDLE: begin
          // Coins arriving here are ignored: nothing is owed.
          if (exit_req) begin
            if (!seat_legal) begin
              err_bad_seat <= 1'b1;
            end else if (sel_cost == '0) begin
              // Nothing owed: ask the meter to clear the seat right away.
              seat_clear     <= 1'b1;
              seat_clear_idx <= exit_seat;
            end else begin
              fare_due <= sel_cost;
              paid_sum <= '0;
              timer    <= TMR_LOAD;
              seat     <= exit_seat;
              state    <= PAY;
            end
          end
        end

        PAY: begin
          if (coin_valid) begin
            paid_sum <= sum_next;
            timer    <= TMR_LOAD;
          end else if (timer != '0) begin
            timer <= timer - TMR_W'(1);
          end

          // Cancel has priority; a coin in the same cycle is still banked so
          // it goes back with the refund.
          if (cancel) begin
            state <= REFUND;
          end else if (coin_valid && (sum_next >= fare_due)) begin
            state <= SETTLE;
          end else if (!coin_valid && (timer == '0)) begin
            state <= REFUND;
          end
        end

        SETTLE: begin
          change_valid    <= 1'b1;
          change_amount   <= paid_sum - fare_due;
          seat_clear      <= 1'b1;
          seat_clear_idx  <= seat;
          collected_total <= collected_total + fare_due;
          paid_sum        <= '0;
          fare_due        <= '0;
          state           <= IDLE;
        end

        REFUND: begin
          // The fare stays on the meter, so no seat_clear here.
          if (paid_sum != '0) begin
            refund_valid  <= 1'b1;
            refund_amount <= paid_sum;
          end
          if (unpaid_count != {CNT_W{1'b1}}) begin
            unpaid_count <= unpaid_count + CNT_W'(1);
          end
          paid_sum <= '0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taxi_fare_collector.sv
// Directed testbench for taxi_fare_collector, built with TIMEOUT=8.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_taxi_fare_collector;

  logic        clock;
  logic        reset_n;
  logic        exit_req;
  logic [2:0]  exit_seat;
  logic [31:0] s0cost, s1cost, s2cost, s3cost, vip_cost;
  logic        coin_valid;
  logic [7:0]  coin_amount;
  logic        cancel;
  logic        busy;
  logic [31:0] fare_due, paid_sum;
  logic        seat_clear;
  logic [2:0]  seat_clear_idx;
  logic        change_valid;
  logic [31:0] change_amount;
  logic        refund_valid;
  logic [31:0] refund_amount;
  logic [31:0] collected_total;
  logic [7:0]  unpaid_count;
  logic        err_bad_seat;

  int checks = 0;
  int errors = 0;

  taxi_fare_collector #(
    .FARE_W(32), .COIN_W(8), .TIMEOUT(8), .CNT_W(8)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .exit_req(exit_req), .exit_seat(exit_seat),
    .s0cost(s0cost), .s1cost(s1cost), .s2cost(s2cost), .s3cost(s3cost),
    .vip_cost(vip_cost),
    .coin_valid(coin_valid), .coin_amount(coin_amount), .cancel(cancel),
    .busy(busy), .fare_due(fare_due), .paid_sum(paid_sum),
    .seat_clear(seat_clear), .seat_clear_idx(seat_clear_idx),
    .change_valid(change_valid), .change_amount(change_amount),
    .refund_valid(refund_valid), .refund_amount(refund_amount),
    .collected_total(collected_total), .unpaid_count(unpaid_count),
    .err_bad_seat(err_bad_seat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic coin(input logic [7:0] amt);
    coin_valid  = 1'b1;
    coin_amount = amt;
    step();
    coin_valid  = 1'b0;
    coin_amount = 8'd0;
  endtask

  task automatic exit_on(input logic [2:0] s);
    exit_req  = 1'b1;
    exit_seat = s;
    step();
    exit_req  = 1'b0;
    exit_seat = 3'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    exit_req = 0; exit_seat = 0; coin_valid = 0; coin_amount = 0; cancel = 0;
    s0cost = 0; s1cost = 0; s2cost = 0; s3cost = 0; vip_cost = 0;
    step(); step();
    checks++;
    if ({busy, fare_due, paid_sum, collected_total, unpaid_count, seat_clear,
         change_valid, refund_valid, err_bad_seat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b fare=%0d paid=%0d total=%0d unpaid=%0d expected all 0",
               busy, fare_due, paid_sum, collected_total, unpaid_count);
    end
    reset_n = 1'b1;
    step();
    // Coin in IDLE is ignored.
    coin(8'd9);
    checks++;
    if (paid_sum !== 32'd0) begin
      errors++; $display("FAIL idle_coin_ignored paid_sum got %0d expected 0", paid_sum);
    end
  endtask

  task automatic test_exact();
    s1cost = 32'd23;
    exit_on(3'd1);
    checks++;
    if (fare_due !== 32'd23) begin
      errors++; $display("FAIL exact_fare_due got %0d expected 23", fare_due);
    end
    coin(8'd10);
    coin(8'd10);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL exact_busy_in_pay got %0b expected 1", busy);
    end
    coin(8'd3);
    checks++;
    if (paid_sum !== 32'd23) begin
      errors++; $display("FAIL exact_paid_sum got %0d expected 23", paid_sum);
    end
    step();
    checks++;
    if (change_valid !== 1'b1 || change_amount !== 32'd0) begin
      errors++; $display("FAIL exact_change got valid=%0b amt=%0d expected valid=1 amt=0",
                         change_valid, change_amount);
    end
    checks++;
    if (seat_clear !== 1'b1 || seat_clear_idx !== 3'd1) begin
      errors++; $display("FAIL exact_seat_clear got %0b idx=%0d expected 1 idx=1",
                         seat_clear, seat_clear_idx);
    end
    checks++;
    if (collected_total !== 32'd23) begin
      errors++; $display("FAIL exact_total got %0d expected 23", collected_total);
    end
    step();
    checks++;
    if (change_valid !== 1'b0 || seat_clear !== 1'b0 || busy !== 1'b0 || paid_sum !== 32'd0) begin
      errors++; $display("FAIL exact_after got cv=%0b sc=%0b busy=%0b paid=%0d expected 0 0 0 0",
                         change_valid, seat_clear, busy, paid_sum);
    end
  endtask

  task automatic test_overpay();
    vip_cost = 32'd41;
    exit_on(3'd4);
    coin(8'd20);
    coin(8'd20);
    coin(8'd50);
    step();
    checks++;
    if (change_valid !== 1'b1 || change_amount !== 32'd49) begin
      errors++; $display("FAIL overpay_change got valid=%0b amt=%0d expected valid=1 amt=49",
                         change_valid, change_amount);
    end
    checks++;
    if (seat_clear_idx !== 3'd4 || collected_total !== 32'd64 || busy !== 1'b1) begin
      errors++; $display("FAIL overpay_clear got idx=%0d total=%0d busy=%0b expected 4 64 1",
                         seat_clear_idx, collected_total, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL overpay_busy_fall got %0b expected 0", busy);
    end
  endtask

  task automatic test_cancel();
    s0cost = 32'd30;
    exit_on(3'd0);
    coin(8'd10);
    cancel = 1'b1;
    coin(8'd5);
    cancel = 1'b0;
    checks++;
    if (paid_sum !== 32'd15) begin
      errors++; $display("FAIL cancel_paid_sum got %0d expected 15", paid_sum);
    end
    step();
    checks++;
    if (refund_valid !== 1'b1 || refund_amount !== 32'd15) begin
      errors++; $display("FAIL cancel_refund got valid=%0b amt=%0d expected valid=1 amt=15",
                         refund_valid, refund_amount);
    end
    checks++;
    if (unpaid_count !== 8'd1 || seat_clear !== 1'b0 || collected_total !== 32'd64) begin
      errors++; $display("FAIL cancel_side got unpaid=%0d sc=%0b total=%0d expected 1 0 64",
                         unpaid_count, seat_clear, collected_total);
    end
    checks++;
    if (seat_clear_idx !== 3'd4) begin
      errors++; $display("FAIL cancel_idx_hold got %0d expected 4", seat_clear_idx);
    end
  endtask

  task automatic test_timeout();
    int rv_seen = 0;
    s2cost = 32'd12;
    exit_on(3'd2);
    for (int i = 0; i < 8; i++) begin
      step();
      if (refund_valid) rv_seen++;
    end
    // REFUND was entered on the 8th PAY edge; the count updates on the next.
    checks++;
    if (unpaid_count !== 8'd1) begin
      errors++; $display("FAIL timeout_early got unpaid=%0d expected 1", unpaid_count);
    end
    step();
    if (refund_valid) rv_seen++;
    checks++;
    if (unpaid_count !== 8'd2) begin
      errors++; $display("FAIL timeout_unpaid got %0d expected 2", unpaid_count);
    end
    checks++;
    if (rv_seen !== 0 || refund_amount !== 32'd15) begin
      errors++; $display("FAIL timeout_refund got pulses=%0d amt=%0d expected 0 15",
                         rv_seen, refund_amount);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL timeout_busy got %0b expected 0", busy);
    end
  endtask

  task automatic test_edges();
    exit_on(3'd6);
    checks++;
    if (err_bad_seat !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_seat got err=%0b busy=%0b expected 1 0", err_bad_seat, busy);
    end
    step();
    checks++;
    if (err_bad_seat !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_seat_after got err=%0b busy=%0b expected 0 0", err_bad_seat, busy);
    end

    s3cost = 32'd0;
    exit_on(3'd3);
    checks++;
    if (seat_clear !== 1'b1 || seat_clear_idx !== 3'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_fare got sc=%0b idx=%0d busy=%0b expected 1 3 0",
                         seat_clear, seat_clear_idx, busy);
    end
    step();
    checks++;
    if (seat_clear !== 1'b0 || seat_clear_idx !== 3'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_fare_after got sc=%0b idx=%0d busy=%0b expected 0 3 0",
                         seat_clear, seat_clear_idx, busy);
    end

    s0cost = 32'd30;
    exit_on(3'd0);
    step();
    s0cost = 32'd99;
    s2cost = 32'd12;
    exit_on(3'd2);
    checks++;
    if (fare_due !== 32'd30 || err_bad_seat !== 1'b0) begin
      errors++; $display("FAIL exit_in_pay got fare=%0d err=%0b expected 30 0", fare_due, err_bad_seat);
    end
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step();
    checks++;
    if (unpaid_count !== 8'd3 || refund_valid !== 1'b0) begin
      errors++; $display("FAIL exit_in_pay_abort got unpaid=%0d rv=%0b expected 3 0",
                         unpaid_count, refund_valid);
    end
    step();
  endtask

  task automatic test_reset_mid_pay();
    s0cost = 32'd30;
    exit_on(3'd0);
    coin(8'd7);
    checks++;
    if (paid_sum !== 32'd7) begin
      errors++; $display("FAIL midpay_paid got %0d expected 7", paid_sum);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, fare_due, paid_sum, collected_total, unpaid_count, seat_clear, seat_clear_idx,
         change_valid, change_amount, refund_valid, refund_amount, err_bad_seat} !== '0) begin
      errors++;
      $display("FAIL midpay_reset got busy=%0b fare=%0d paid=%0d total=%0d unpaid=%0d ramt=%0d expected all 0",
               busy, fare_due, paid_sum, collected_total, unpaid_count, refund_amount);
    end
    #1 reset_n = 1'b1;
    step();
    step();
    checks++;
    if (refund_valid !== 1'b0 || busy !== 1'b0 || unpaid_count !== 8'd0) begin
      errors++; $display("FAIL midpay_after got rv=%0b busy=%0b unpaid=%0d expected 0 0 0",
                         refund_valid, busy, unpaid_count);
    end
  endtask

  task automatic test_saturate();
    s0cost = 32'd30;
    for (int i = 0; i < 255; i++) begin
      exit_on(3'd0);
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      step();
    end
    checks++;
    if (unpaid_count !== 8'd255) begin
      errors++; $display("FAIL sat_reach got %0d expected 255", unpaid_count);
    end
    exit_on(3'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step();
    checks++;
    if (unpaid_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold got %0d expected 255", unpaid_count);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_overpay();
    test_cancel();
    test_timeout();
    test_edges();
    test_reset_mid_pay();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/taxi_fare_collector.md
Name: taxi_fare_collector

Overview:
Payment end of the taxi meter. When a passenger leaves, this block latches the fare the meter has accumulated for that seat (seats 0-3 or VIP). It then accepts coins until the fare is covered, returns change, and pulses a clear request back to the meter for that seat. It also keeps its own collected-cash total and a count of abandoned or unpaid exits.

Parameters:
FARE_W, 32, width of every fare, sum and total bus.
COIN_W, 8, width of coin_amount.
TIMEOUT, 64, idle cycles in PAY (no coin) before the payment is abandoned; minimum 2.
CNT_W, 8, width of unpaid_count.

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
exit_req  in  1  one-cycle request: a passenger is leaving the seat given by exit_seat.
exit_seat  in  3  0-3 = seat_0..seat_3, 4 = VIP; 5-7 are illegal.
s0cost, s1cost, s2cost, s3cost, vip_cost  in  FARE_W each  live fares from the meter.
coin_valid  in  1  one coin inserted this cycle.
coin_amount  in  COIN_W  value of the coin.
cancel  in  1  passenger aborts payment.
busy  out  1  high in any state other than IDLE.
fare_due  out  FARE_W  latched fare of the current exit.
paid_sum  out  FARE_W  coins accumulated for the current exit.
seat_clear  out  1  one-cycle pulse: meter must zero the seat given by seat_clear_idx.
seat_clear_idx  out  3  seat being cleared.
change_valid  out  1  one-cycle pulse; change_amount is valid.
change_amount  out  FARE_W  paid_sum minus fare_due.
refund_valid  out  1  one-cycle pulse; refund_amount is valid.
refund_amount  out  FARE_W  coins returned on an abort.
collected_total  out  FARE_W  sum of all settled fares.
unpaid_count  out  CNT_W  number of aborted or timed-out exits; saturates at all ones.
err_bad_seat  out  1  one-cycle pulse on an exit_req with an illegal seat.

Behaviour:
- Output registers: all outputs are registered.
- Reset values: reset_n low forces every output and internal register to 0 and the state to IDLE, immediately and in any state.
- Reset mid-payment: any paid_sum is discarded; there is no refund pulse.
- States: IDLE, PAY, SETTLE, REFUND, encoded in 2 bits.
- IDLE, exit_req with exit_seat<=4 and selected cost nonzero:
  - At that edge: latch the cost into fare_due, clear paid_sum and the timeout counter.
  - Go to PAY; busy rises the next cycle.
- IDLE, exit_req with a legal seat and selected cost==0:
  - No payment is taken.
  - seat_clear pulses on the next cycle with that index.
  - Stay in IDLE.
- IDLE, exit_req with exit_seat>=5: err_bad_seat pulses for 1 cycle; stay in IDLE.
- exit_req while busy: ignored, with no error pulse.
- coin_valid in IDLE: ignored.
- PAY, coin arrival: on coin_valid, paid_sum += coin_amount (zero-extended, modulo 2^FARE_W) and the timeout counter clears.
- PAY, fare covered: if the updated paid_sum >= fare_due, go to SETTLE.
- PAY, timeout: with no coin_valid, the counter increments; when it reaches TIMEOUT-1, go to REFUND.
- PAY, cancel: go to REFUND.
- PAY, cancel with coin_valid in the same cycle: cancel wins, and the coin is added to paid_sum so it is refunded.
- SETTLE (exactly 1 cycle):
  - Drive change_valid=1 and change_amount=paid_sum-fare_due (this may be 0; the pulse still fires).
  - Drive seat_clear=1 with seat_clear_idx set.
  - collected_total += fare_due, modulo 2^FARE_W.
  - Next state IDLE; paid_sum and fare_due clear on the exit edge.
  - Inputs sampled during SETTLE are ignored.
- REFUND (exactly 1 cycle):
  - refund_valid=1 only if paid_sum!=0, with refund_amount=paid_sum.
  - unpaid_count increments and saturates.
  - No seat_clear: the fare stays on the meter.
  - Next state IDLE; paid_sum clears.
- Latency, coin to pulses: coin covering the fare at edge N gives change_valid and seat_clear high during the cycle after edge N+1. busy falls after edge N+2.
- Latency, exit to payable: exit_req sampled at edge N lets coins be accepted from edge N+1.
- Fare source: fare_due is a snapshot; later changes on the sN cost inputs do not affect the current exit.
- Non-pulse outputs hold their value outside their pulse cycle:
  - change_amount and refund_amount hold their last value.
  - seat_clear_idx holds until the next clear.

Test Plan:
- Reset: assert reset_n=0 mid-PAY with paid_sum=7 -> all outputs 0, state IDLE, no refund_valid.
- Exact payment: s1cost=23, exit_req seat 1, coins 10, 10, 3 -> SETTLE; change_amount=0 with change_valid pulse, seat_clear idx=1, collected_total=23.
- Overpay: vip_cost=41, exit_req seat 4, coins 20, 20, 50 -> change_amount=49, seat_clear idx=4, collected_total increases by 41; busy low 2 cycles after the last coin.
- Cancel: s0cost=30, coins 10 then cancel together with coin 5 -> refund_amount=15, unpaid_count=1, no seat_clear.
- Timeout: TIMEOUT=8, exit seat 2 with s2cost=12, no coins -> REFUND 8 cycles after entering PAY, refund_valid stays 0, unpaid_count increments.
- Edge cases:
  - exit_seat=6 -> err_bad_seat pulse.
  - s3cost=0 exit -> seat_clear idx=3 next cycle, busy stays 0.
  - exit_req during PAY -> ignored, fare_due unchanged.
  - unpaid_count at 255 plus one abort -> stays 255.
